// File: rtl/wb_stage_writer_if.sv
// rtl/wb_stage_writer_if.sv - writeback beat input and register-file write port bundle
interface wb_stage_writer_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_Reg_Write_Ctrl;
  logic              in_Byte_Word;
  logic              in_Mem_Or_Reg;
  logic [1:0]        in_byte_sel;
  logic [DATA_W-1:0] in_mem_data;
  logic [DATA_W-1:0] in_alu_result;
  logic [REG_AW-1:0] in_dest_reg;
  logic              rf_we;
  logic              rf_ready;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output in_valid, in_Reg_Write_Ctrl, in_Byte_Word, in_Mem_Or_Reg,
           in_byte_sel, in_mem_data, in_alu_result, in_dest_reg, rf_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, in_Reg_Write_Ctrl, in_Byte_Word, in_Mem_Or_Reg,
           in_byte_sel, in_mem_data, in_alu_result, in_dest_reg, rf_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_stage_writer.sv
// rtl/wb_stage_writer.sv - 2-entry writeback buffer resolving load/ALU results into RF writes; WB_FWD_EN adds youngest-entry forwarding
module wb_stage_writer #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_stage_writer_if.slave  wb,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  logic [REG_AW-1:0] addr_q [2];
  logic [DATA_W-1:0] data_q [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic [DATA_W-1:0] src;
  logic [7:0]        lane;
  logic [DATA_W-1:0] resolved;
  logic              keep;
  logic              enq;
  logic              deq;

  always_comb begin
    src      = wb.in_Mem_Or_Reg ? wb.in_mem_data : wb.in_alu_result;
    lane     = src[{wb.in_byte_sel, 3'b000} +: 8];
    resolved = wb.in_Byte_Word ? {{(DATA_W-8){lane[7]}}, lane} : src;
  end

  // Beats that would not write a real register never occupy a slot.
  assign keep = wb.in_Reg_Write_Ctrl && (wb.in_dest_reg != '0);
  assign enq  = wb.in_valid && wb.in_ready && keep;
  assign deq  = wb.rf_we && wb.rf_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) begin
        addr_q[wr_ptr] <= wb.in_dest_reg;
        data_q[wr_ptr] <= resolved;
        wr_ptr         <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // No pass-through: a full buffer refuses even when the head drains this cycle.
  assign wb.in_ready = (count < 2'd2);
  assign wb.rf_we    = (count != 2'd0);
  assign wb.rf_waddr = wb.rf_we ? addr_q[rd_ptr] : '0;
  assign wb.rf_wdata = wb.rf_we ? data_q[rd_ptr] : '0;
  assign occupancy   = count;

`ifdef WB_FWD_EN
  // Youngest entry sits just behind the write pointer.
  assign fwd_valid = (count != 2'd0);
  assign fwd_reg   = fwd_valid ? addr_q[~wr_ptr] : '0;
  assign fwd_data  = fwd_valid ? data_q[~wr_ptr] : '0;
`endif

endmodule
